// File: rtl/seq_detect_fsm_pkg.sv
// Shared types, limits and sizing helper for the serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10
  } state_e;

  // Smallest r with 2**r >= v; used to size the valid-bit counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_if.sv
// Serial data, pattern load and status bundle of the pattern detector.
interface seq_detect_fsm_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);

  logic             en;
  logic             x;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             match;
  logic [CNT_W-1:0] count;
  logic             armed;

  modport master (
    output en, x, pat_load, pat_in,
    input  match, count, armed
  );

  modport slave (
    input  en, x, pat_load, pat_in,
    output match, count, armed
  );

endinterface

// File: rtl/seq_detect_fsm_shift_hist.sv
// N-bit history shift register; newest bit enters at the LSB.
module shift_hist #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] hist_q;

  // Clear has priority over shifting so a load or non-overlap match discards x.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      hist_q <= '0;
    end else if (en_i) begin
      hist_q <= {hist_q[N-2:0], d_i};
    end
  end

  assign q_o = hist_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: fill/armed FSM, pattern comparator and saturating match counter.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int unsigned    N        = 4,
  parameter int unsigned    CNT_W    = 8,
  parameter bit             OVERLAP  = 1'b1,
  parameter logic [N-1:0]   PAT_INIT = N'(4'b1011)
) (
  input logic            clk,
  input logic            reset,
  seq_detect_fsm_if.slave bus
);

  localparam int unsigned    FW        = clog2(N + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
    $fatal(1, "seq_detect_fsm: N=%0d outside legal range", N);
  end

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [N-1:0]     pattern_q, pattern_d;
  logic [N-1:0]     hist_q, hist_next;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             armed_q, armed_d;
  logic             accept, hit, hist_clr;
  logic             unused_hist_msb;

  // A bit is consumed only when valid and not colliding with a pattern load.
  assign accept    = bus.en && !bus.pat_load;
  assign hist_next = {hist_q[N-2:0], bus.x};
  assign fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  assign hit       = accept && (fill_inc == FILL_FULL) && (hist_next == pattern_q);
  assign hist_clr  = bus.pat_load || (hit && !OVERLAP);

  assign unused_hist_msb = hist_q[N-1];

  shift_hist #(.N(N)) u_hist (
    .clk   (clk),
    .reset (reset),
    .clr_i (hist_clr),
    .en_i  (accept),
    .d_i   (bus.x),
    .q_o   (hist_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, fill and pattern selection.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    if (bus.pat_load) begin
      pattern_d = bus.pat_in;
      fill_d    = '0;
      state_d   = EMPTY;
    end else if (accept) begin
      if (hit && !OVERLAP) begin
        fill_d  = '0;
        state_d = EMPTY;
      end else begin
        fill_d = fill_inc;
        case (state_q)
          EMPTY:   state_d = (fill_inc == FILL_FULL) ? ARMED : FILL;
          FILL:    state_d = (fill_inc == FILL_FULL) ? ARMED : FILL;
          ARMED:   state_d = ARMED;
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // Output values for the next cycle: match pulse, saturating count, armed flag.
  always_comb begin
    match_d = hit;
    count_d = count_q;
    armed_d = (state_d == ARMED);
    if (hit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q    <= '0;
      pattern_q <= PAT_INIT;
      match_q   <= 1'b0;
      count_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      match_q   <= match_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
    end
  end

  assign bus.match = match_q;
  assign bus.count = count_q;
  assign bus.armed = armed_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three configurations driven in parallel against a queue-based model.
module tb_seq_detect_fsm;

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic       pat_load;
  logic [3:0] pat_in;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // a: overlap, 8-bit count; b: non-overlap; c: overlap, 2-bit count
  seq_detect_fsm_if #(.N(4), .CNT_W(8)) if_a ();
  seq_detect_fsm_if #(.N(4), .CNT_W(8)) if_b ();
  seq_detect_fsm_if #(.N(4), .CNT_W(2)) if_c ();

  assign if_a.en = en; assign if_a.x = x; assign if_a.pat_load = pat_load; assign if_a.pat_in = pat_in;
  assign if_b.en = en; assign if_b.x = x; assign if_b.pat_load = pat_load; assign if_b.pat_in = pat_in;
  assign if_c.en = en; assign if_c.x = x; assign if_c.pat_load = pat_load; assign if_c.pat_in = pat_in;

  seq_detect_fsm #(.N(4), .CNT_W(8), .OVERLAP(1'b1), .PAT_INIT(4'b1011)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  seq_detect_fsm #(.N(4), .CNT_W(8), .OVERLAP(1'b0), .PAT_INIT(4'b1011)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  seq_detect_fsm #(.N(4), .CNT_W(2), .OVERLAP(1'b1), .PAT_INIT(4'b1011)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave));

  logic       d_match [3];
  logic [7:0] d_count [3];
  logic       d_armed [3];
  assign d_match[0] = if_a.match; assign d_count[0] = if_a.count;          assign d_armed[0] = if_a.armed;
  assign d_match[1] = if_b.match; assign d_count[1] = if_b.count;          assign d_armed[1] = if_b.armed;
  assign d_match[2] = if_c.match; assign d_count[2] = {6'b0, if_c.count};  assign d_armed[2] = if_c.armed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: last accepted bits kept in a queue (oldest first), cleared on load/reset.
  bit [3:0] m_pat   [3];
  bit       m_q     [3][$];
  int       m_cnt   [3];
  bit       m_match [3];
  int       m_max   [3] = '{255, 255, 3};
  bit       m_ovl   [3] = '{1'b1, 1'b0, 1'b1};

  always @(posedge clk) begin
    bit [3:0] v;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_pat[i] = 4'b1011;
        m_q[i].delete();
        m_cnt[i] = 0;
        m_match[i] = 1'b0;
      end else if (pat_load) begin
        m_pat[i] = pat_in;
        m_q[i].delete();
        m_match[i] = 1'b0;
      end else if (en) begin
        m_q[i].push_back(x);
        if (m_q[i].size() > 4) void'(m_q[i].pop_front());
        v = 4'b0;
        for (int k = 0; k < m_q[i].size(); k++) v = {v[2:0], m_q[i][k]};
        m_match[i] = (m_q[i].size() == 4) && (v == m_pat[i]);
        if (m_match[i]) begin
          if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
          if (!m_ovl[i]) m_q[i].delete();
        end
      end else begin
        m_match[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("match[%0d]", i), 32'(d_match[i]), 32'(m_match[i]));
        chk($sformatf("count[%0d]", i), 32'(d_count[i]), 32'(m_cnt[i]));
        chk($sformatf("armed[%0d]", i), 32'(d_armed[i]), 32'(m_q[i].size() == 4));
      end
    end
  end

  task automatic cyc(input bit e, input bit xb, input bit pl, input bit [3:0] pi, input bit rs);
    en = e; x = xb; pat_load = pl; pat_in = pi; reset = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit [3:0] v);
    for (int k = 3; k >= 0; k--) cyc(1'b1, v[k], 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = 4'h0; reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk_on = 1'b1;
    chk("rst_match", 32'(if_a.match), 32'd0);
    chk("rst_count", 32'(if_a.count), 32'd0);
    chk("rst_armed", 32'(if_a.armed), 32'd0);

    // Basic detect of the reset pattern 1011.
    send(4'b1011);
    chk("basic_match_a", 32'(if_a.match), 32'd1);
    chk("basic_armed_a", 32'(if_a.armed), 32'd1);
    chk("basic_count_a", 32'(if_a.count), 32'd1);
    chk("basic_armed_b", 32'(if_b.armed), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("pulse_width_a", 32'(if_a.match), 32'd0);

    // Self-overlapping pattern 1010 over stream 101010.
    cyc(1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
    send(4'b1010);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("ovl_count_a", 32'(if_a.count), 32'd3);
    chk("novl_count_b", 32'(if_b.count), 32'd2);

    // en gap between bits 2 and 3.
    cyc(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("gap_match_a", 32'(if_a.match), 32'd1);
    chk("gap_count_a", 32'(if_a.count), 32'd4);

    // Load collides with a valid bit: x=1 must be dropped, count kept.
    cyc(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    chk("coll_armed_a", 32'(if_a.armed), 32'd0);
    chk("coll_count_a", 32'(if_a.count), 32'd4);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("coll_nomatch_a", 32'(if_a.count), 32'd4);

    // Reset mid-stream discards a partial 101.
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("midrst_count_a", 32'(if_a.count), 32'd0);
    chk("midrst_armed_a", 32'(if_a.armed), 32'd0);
    send(4'b1011);
    chk("midrst_one_a", 32'(if_a.count), 32'd1);

    // Five more matches: 2-bit counter saturates at 3.
    repeat (5) send(4'b1011);
    chk("sat_count_c", 32'(if_c.count), 32'd3);
    chk("sat_count_a", 32'(if_a.count), 32'd6);
    chk("sat_count_b", 32'(if_b.count), 32'd6);

    // Randomised phase; pattern loads and resets are rare.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 199) == 0));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
